// File: rtl/pin_input_conditioner_if.sv
// Bundle of the pin conditioner's data-side signals.
//   RAW_IN   : raw, asynchronous switch/button levels (into the conditioner)
//   CLR_EVT  : per-bit clear strobe for the sticky event flags (into the conditioner)
//   PIN      : debounced, synchronized level (out of the conditioner)
//   RISE     : one-cycle pulse per bit on a 0->1 change of PIN (out)
//   EVT      : sticky rising-edge flags (out)
//   EVT_ANY  : registered OR of EVT (out)
// Handshake: there is no valid/ready pair. Every signal is a level, sampled
// on each rising clock edge. CLR_EVT is a one-cycle strobe per bit, and a set
// on the same edge overrides it.
// Modports: master = CPU/pin side that drives RAW_IN and CLR_EVT;
//           slave  = the conditioner itself.
interface pin_input_conditioner_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] RAW_IN;
  logic [WIDTH-1:0] CLR_EVT;
  logic [WIDTH-1:0] PIN;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] EVT;
  logic             EVT_ANY;

  modport master (
    output RAW_IN, CLR_EVT,
    input  PIN, RISE, EVT, EVT_ANY
  );

  modport slave (
    input  RAW_IN, CLR_EVT,
    output PIN, RISE, EVT, EVT_ANY
  );
endinterface

// File: rtl/pin_input_conditioner.sv
// Conditions raw external input pins before they reach the PIN bus.
// Each bit passes through a 2-FF synchronizer and then a consecutive-sample
// debouncer: a new level is accepted only after DEB_CYCLES consecutive edges
// at which the synchronized sample disagrees with the current PIN value.
// Accepted 0->1 changes give a one-cycle RISE pulse and set a sticky EVT flag
// that the CPU clears with CLR_EVT.
// Ports:
//   CLK : system clock, all state on the rising edge
//   RST : synchronous reset, active-high, overrides everything
//   bus : pin_input_conditioner_if.slave (RAW_IN, CLR_EVT in; PIN, RISE,
//         EVT, EVT_ANY out)
module pin_input_conditioner #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  pin_input_conditioner_if.slave   bus
);
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] pin_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] evt_q;
  logic             evt_any_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];

  logic [WIDTH-1:0] pin_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] evt_nxt;
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  // Per-bit debounce. The counter holds how many consecutive mismatches have
  // been seen so far; the DEB_CYCLES-th mismatch flips PIN instead of
  // counting, so the counter never passes CNT_MAX. Any matching sample, or
  // an acceptance, restarts the count at zero.
  always_comb begin
    pin_nxt = pin_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2_q[i] != pin_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          pin_nxt[i] = sync2_q[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_nxt = pin_nxt & ~pin_q;
    // A rise on the same edge as a clear wins, so no press is lost.
    evt_nxt  = rise_nxt | (evt_q & ~bus.CLR_EVT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pin_q     <= '0;
      rise_q    <= '0;
      evt_q     <= '0;
      evt_any_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.RAW_IN;
      sync2_q   <= sync1_q;
      pin_q     <= pin_nxt;
      rise_q    <= rise_nxt;
      evt_q     <= evt_nxt;
      // Derived from the next EVT value so EVT_ANY lines up with EVT.
      evt_any_q <= |evt_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
    end
  end

  assign bus.PIN     = pin_q;
  assign bus.RISE    = rise_q;
  assign bus.EVT     = evt_q;
  assign bus.EVT_ANY = evt_any_q;
endmodule

// File: tb/tb_pin_input_conditioner.sv
module tb_pin_input_conditioner;
  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  pin_input_conditioner_if #(.WIDTH(WIDTH)) bus ();

  pin_input_conditioner #(.WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Sampled-level view: a PIN bit flips when the last DEB synchronized
  // samples (taken at the last DEB edges) all disagree with it.
  logic [WIDTH-1:0] m_sync1, m_sync2, m_pin, m_rise, m_evt;
  logic             m_any;
  logic [WIDTH-1:0] hist[$];

  task automatic model_edge();
    logic [WIDTH-1:0] new_pin;
    logic             flip;
    if (RST) begin
      m_sync1 = '0; m_sync2 = '0; m_pin = '0; m_rise = '0; m_evt = '0; m_any = 1'b0;
      hist.delete();
      for (int k = 0; k < DEB; k++) hist.push_back('0);
    end else begin
      hist.push_back(m_sync2);
      if (hist.size() > DEB) void'(hist.pop_front());
      new_pin = m_pin;
      for (int i = 0; i < WIDTH; i++) begin
        flip = 1'b1;
        foreach (hist[k]) if (hist[k][i] == m_pin[i]) flip = 1'b0;
        if (flip) new_pin[i] = ~m_pin[i];
      end
      m_rise  = new_pin & ~m_pin;
      m_evt   = m_rise | (m_evt & ~bus.CLR_EVT);
      m_any   = |m_evt;
      m_pin   = new_pin;
      m_sync2 = m_sync1;
      m_sync1 = bus.RAW_IN;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: model follows the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] raw, input int settle);
    RST = 1'b1;
    bus.RAW_IN = raw;
    bus.CLR_EVT = '0;
    tick();
    tick();
    RST = 1'b0;
    for (int k = 0; k < settle; k++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first;
    RST = 1'b1;
    bus.RAW_IN = 8'hFF;
    bus.CLR_EVT = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY} !== 25'd0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected 0", {bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY});
      end
    end
    RST = 1'b0;
    // Edge index 0 is the first edge with RST low; acceptance lands on index 5.
    first = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY} !== {m_pin, m_rise, m_evt, m_any}) begin
        errors++;
        $display("FAIL reset_model k=%0d: got %h expected %h", k,
                 {bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY}, {m_pin, m_rise, m_evt, m_any});
      end
      if (first < 0 && bus.PIN == 8'hFF) begin
        first = k;
        checks++;
        if ({bus.RISE, bus.EVT, bus.EVT_ANY} !== {8'hFF, 8'hFF, 1'b1}) begin
          errors++;
          $display("FAIL reset_accept_flags: got %h expected %h",
                   {bus.RISE, bus.EVT, bus.EVT_ANY}, {8'hFF, 8'hFF, 1'b1});
        end
      end
    end
    checks++;
    if (first != 5) begin
      errors++;
      $display("FAIL reset_accept_edge: got %0d expected 5", first);
    end
    checks++;
    if (bus.RISE !== 8'h00) begin
      errors++;
      $display("FAIL reset_rise_single: got %h expected 00", bus.RISE);
    end
  endtask

  task automatic test_fall();
    int  first;
    logic saw_rise;
    first = -1;
    saw_rise = 1'b0;
    bus.RAW_IN = 8'hF7;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY} !== {m_pin, m_rise, m_evt, m_any}) begin
        errors++;
        $display("FAIL fall_model k=%0d: got %h expected %h", k,
                 {bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY}, {m_pin, m_rise, m_evt, m_any});
      end
      if (first < 0 && bus.PIN[3] == 1'b0) first = k;
      if (bus.RISE[3]) saw_rise = 1'b1;
    end
    checks++;
    if (first != 5) begin
      errors++;
      $display("FAIL fall_accept_edge: got %0d expected 5", first);
    end
    checks++;
    if (saw_rise !== 1'b0 || bus.EVT[3] !== 1'b1) begin
      errors++;
      $display("FAIL fall_no_event: got rise=%b evt3=%b expected rise=0 evt3=1", saw_rise, bus.EVT[3]);
    end
  endtask

  task automatic test_clear();
    bus.CLR_EVT = 8'hFB;
    tick();
    bus.CLR_EVT = '0;
    checks++;
    if ({bus.EVT, bus.EVT_ANY} !== {8'h04, 1'b1}) begin
      errors++;
      $display("FAIL clear_others: got %h expected %h", {bus.EVT, bus.EVT_ANY}, {8'h04, 1'b1});
    end
    bus.CLR_EVT = 8'h04;
    tick();
    bus.CLR_EVT = '0;
    checks++;
    if ({bus.EVT, bus.EVT_ANY} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL clear_bit2: got %h expected %h", {bus.EVT, bus.EVT_ANY}, {8'h00, 1'b0});
    end
    tick();
    checks++;
    if ({bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY} !== {m_pin, m_rise, m_evt, m_any}) begin
      errors++;
      $display("FAIL clear_model: got %h expected %h",
               {bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY}, {m_pin, m_rise, m_evt, m_any});
    end
  endtask

  task automatic test_set_wins();
    logic found;
    bus.RAW_IN = bus.RAW_IN & ~8'h20;
    for (int k = 0; k < 8; k++) tick();
    // Clear held high for bit 5 across the whole rise.
    bus.CLR_EVT = 8'h20;
    bus.RAW_IN = bus.RAW_IN | 8'h20;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY} !== {m_pin, m_rise, m_evt, m_any}) begin
        errors++;
        $display("FAIL set_wins_model k=%0d: got %h expected %h", k,
                 {bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY}, {m_pin, m_rise, m_evt, m_any});
      end
      if (k == 5) begin
        found = 1'b1;
        checks++;
        if ({bus.RISE[5], bus.EVT[5], bus.EVT_ANY} !== 3'b111) begin
          errors++;
          $display("FAIL set_wins_flags: got %b expected 111", {bus.RISE[5], bus.EVT[5], bus.EVT_ANY});
        end
      end
    end
    bus.CLR_EVT = '0;
    checks++;
    if (found !== 1'b1 || bus.EVT[5] !== 1'b0) begin
      errors++;
      $display("FAIL set_wins_later_clear: got evt5=%b expected 0", bus.EVT[5]);
    end
  endtask

  task automatic test_glitch();
    logic seq [12];
    int   first;
    logic [7:0] pat;
    do_reset(8'h00, 6);
    pat = 8'b1110_1111;   // first eight values, oldest in MSB: 1,1,1,0,1,1,1,1
    for (int k = 0; k < 8; k++) seq[k] = pat[7-k];
    for (int k = 8; k < 12; k++) seq[k] = 1'b1;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      bus.RAW_IN[0] = seq[k];
      tick();
      checks++;
      if ({bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY} !== {m_pin, m_rise, m_evt, m_any}) begin
        errors++;
        $display("FAIL glitch_model k=%0d: got %h expected %h", k,
                 {bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY}, {m_pin, m_rise, m_evt, m_any});
      end
      if (first < 0 && bus.PIN[0]) first = k;
    end
    // Mismatches at 2,3,4, match at 5, then 6..9 -> acceptance at index 9.
    checks++;
    if (first != 9) begin
      errors++;
      $display("FAIL glitch_accept_edge: got %0d expected 9", first);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    do_reset(8'h00, 6);
    bus.RAW_IN = 8'h02;
    for (int k = 0; k < 4; k++) tick();   // counter for bit 1 now at 2
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", {bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY});
    end
    first = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY} !== {m_pin, m_rise, m_evt, m_any}) begin
        errors++;
        $display("FAIL reset_mid_model k=%0d: got %h expected %h", k,
                 {bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY}, {m_pin, m_rise, m_evt, m_any});
      end
      if (first < 0 && bus.PIN[1]) first = k;
    end
    checks++;
    if (first != 5) begin
      errors++;
      $display("FAIL reset_mid_accept_edge: got %0d expected 5", first);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] raw;
    do_reset($urandom_range(0, 255), 0);
    raw = bus.RAW_IN;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < WIDTH; i++)
        if ($urandom_range(0, 5) == 0) raw[i] = ~raw[i];
      bus.RAW_IN  = raw;
      bus.CLR_EVT = WIDTH'($urandom & $urandom & $urandom);
      RST = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if ({bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY} !== {m_pin, m_rise, m_evt, m_any}) begin
        errors++;
        $display("FAIL random_model c=%0d: got %h expected %h", c,
                 {bus.PIN, bus.RISE, bus.EVT, bus.EVT_ANY}, {m_pin, m_rise, m_evt, m_any});
      end
    end
    RST = 1'b0;
    bus.CLR_EVT = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RST = 1'b1;
    bus.RAW_IN = '0;
    bus.CLR_EVT = '0;
    test_reset();
    test_fall();
    test_clear();
    test_set_wins();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
